amber128_capfile_wb_arb: RTL and testbench
==========================================

// Module: amber128_capfile_wb_arb
//
// PURPOSE
// Shares the capability file's single write port between NUM_REQ writeback producers (ALU, cap-load return, trap/CSR unit).
// Round-robin arbitration, one registered write stage driving we/waddr/wdata of amber128_capfile.
// Holds a per-register busy scoreboard for decode-side RAW/WAW hazard checks.
// Sits between the execute/memory writeback paths and the capability file.
//
// PARAMETERS
// NUM_REQ       3                   number of writeback requesters (>=2)
// CAP_REG_AW    amber128_pkg value   capability register address width
// CAP_REG_COUNT amber128_pkg value   number of capability registers
// C_XLEN        amber128_pkg value   capability word width
//
// PORTS
// clk_i          in   1                  clock
// rst_i          in   1                  reset, asynchronous, active-high
// req_valid_i    in   NUM_REQ            writeback request valid, one per requester
// req_ready_o    out  NUM_REQ            grant; the request is accepted this cycle
// req_addr_i     in   NUM_REQ*CAP_REG_AW destination register per requester
// req_data_i     in   NUM_REQ*C_XLEN     capability data per requester
// alloc_valid_i  in   1                  decode allocates a destination; sets its busy bit
// alloc_addr_i   in   CAP_REG_AW         register being allocated
// flush_i        in   1                  pipeline flush; clears the scoreboard
// busy_o         out  CAP_REG_COUNT      scoreboard, bit r = write to r pending
// cf_we_o        out  1                  to capfile we_i
// cf_waddr_o     out  CAP_REG_AW         to capfile waddr_i
// cf_wdata_o     out  C_XLEN             to capfile wdata_i
// sb_err_o       out  1                  sticky: a write committed to a non-busy register
//
// BEHAVIOUR
// - Reset, asynchronous on rst_i: cf_we_o=0, cf_waddr_o=0, cf_wdata_o=0, busy_o=0, sb_err_o=0, RR pointer=0.
// - Handshake: a request transfers when req_valid_i[k] & req_ready_o[k].
//   - req_ready_o is combinational from req_valid_i and the pointer; at most one bit is set.
//   - req_ready_o[k] never asserts without req_valid_i[k].
//   - A requester holds valid/addr/data stable until granted.
// - Arbitration: search starts at the pointer and increments mod NUM_REQ; the first valid requester wins.
//   - After a grant to k, pointer <= (k+1) mod NUM_REQ.
//   - With no grant the pointer is unchanged.
// - Write stage: the capfile always accepts, so the stage never stalls and there is one grant per cycle max.
//   - Grant at edge N: cf_we_o=1 with the granted addr/data during cycle N+1.
//   - The capfile is written at the end of cycle N+1. Latency 1 cycle.
//   - No grant: cf_we_o=0; addr/data hold their last values.
// - Scoreboard update, per register r, per edge:
//   - set = alloc_valid_i & alloc_addr_i==r.
//   - clr = cf_we_o & cf_waddr_o==r.
//   - next = set ? 1 : (clr ? 0 : busy).
//   - Alloc and commit to the same register in one cycle: busy stays 1, because the new producer wins.
//   - flush_i=1: every bit goes to 0 except a bit set by a simultaneous alloc. Flush wins over clr.
//   - flush_i does not cancel a write already in the write stage; it still commits.
// - sb_err_o: set at the edge where cf_we_o=1 and busy_o[cf_waddr_o]=0 with no flush that cycle. Cleared only by reset.
// - Two requesters targeting the same register in one cycle: serialised in RR order. No merging, no error.
// - Reset mid-operation: an in-flight write is dropped and req_ready_o goes to 0 immediately.
//
// STRUCTURE
// - amber128_pkg gets typedef cap_wb_req_t {logic [CAP_REG_AW-1:0] addr; logic [C_XLEN-1:0] data;}.
// - The existing CAP_REG_AW, CAP_REG_COUNT and C_XLEN come from amber128_pkg.
// - Sub-module amber128_rr_arbiter #(N): req, ptr in -> one-hot gnt, next ptr. Reused for other shared ports.
// - Top level holds the write register, the scoreboard and the error flag.
//
// TESTING
// 1. Reset with req_valid_i=3'b111 held -> no grant while rst_i=1, cf_we_o=0, busy_o=0.
//    After release, grants go 0,1,2,0,...
// 2. Single request, req 1: addr=5, data=0xA5.., granted at edge N -> cf_we_o=1, waddr=5 in cycle N+1.
//    cf_we_o=0 in cycle N+2 if idle.
// 3. Alloc r7 -> busy_o[7]=1 next cycle. Req 0 writes r7 -> busy_o[7]=0 one cycle after cf_we_o.
//    sb_err_o stays 0.
// 4. In one cycle, alloc r3 while cf_waddr_o=3 commits -> busy_o[3] remains 1.
// 5. busy={r2,r9}, flush_i with alloc r4 -> busy_o has only bit 4 set. A write in the stage still commits.
// 6. Write to r11 with busy_o[11]=0 -> sb_err_o=1 and stays 1 until reset.

Source files
------------

// File: rtl/amber128_pkg.sv
// amber128_pkg: shared capability widths and the writeback request type
package amber128_pkg;
    localparam int CAP_REG_AW    = 4;
    localparam int CAP_REG_COUNT = 16;
    localparam int C_XLEN        = 128;
    typedef struct packed {
        logic [CAP_REG_AW-1:0] addr;
        logic [C_XLEN-1:0]     data;
    } cap_wb_req_t;
endpackage

// File: rtl/amber128_rr_arbiter.sv
// amber128_rr_arbiter: round-robin pick starting at i_ptr, one-hot grant and advanced pointer
module amber128_rr_arbiter #(
    parameter int N = 3,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [PW-1:0] o_nxt_ptr
);
    logic w_found;
    int   w_idx;
    // first requester at or after the pointer wins; pointer moves just past it
    always_comb begin
        o_gnt     = '0;
        o_nxt_ptr = i_ptr;
        w_found   = 1'b0;
        w_idx     = 0;
        for (int i = 0; i < N; i++) begin
            w_idx = (int'(i_ptr) + i) % N;
            if (!w_found && i_req[w_idx]) begin
                w_found      = 1'b1;
                o_gnt[w_idx] = 1'b1;
                o_nxt_ptr    = PW'((w_idx + 1) % N);
            end
        end
    end
endmodule

// File: rtl/amber128_capfile_wb_arb.sv
// amber128_capfile_wb_arb: round-robin writeback arbiter, write stage and busy scoreboard for the capfile
module amber128_capfile_wb_arb
    import amber128_pkg::*;
#(
    parameter int NUM_REQ = 3,
    localparam int PW = $clog2(NUM_REQ)
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NUM_REQ-1:0]             req_valid_i,
    output logic [NUM_REQ-1:0]             req_ready_o,
    input  logic [NUM_REQ*CAP_REG_AW-1:0]  req_addr_i,
    input  logic [NUM_REQ*C_XLEN-1:0]      req_data_i,
    input  logic                           alloc_valid_i,
    input  logic [CAP_REG_AW-1:0]          alloc_addr_i,
    input  logic                           flush_i,
    output logic [CAP_REG_COUNT-1:0]       busy_o,
    output logic                           cf_we_o,
    output logic [CAP_REG_AW-1:0]          cf_waddr_o,
    output logic [C_XLEN-1:0]              cf_wdata_o,
    output logic                           sb_err_o
);
    logic [PW-1:0]            r_ptr;
    logic [PW-1:0]            w_nxt_ptr;
    logic [NUM_REQ-1:0]       w_gnt;
    logic                     w_any;
    cap_wb_req_t              w_sel;
    logic [CAP_REG_COUNT-1:0] w_set;
    logic [CAP_REG_COUNT-1:0] w_clr;

    amber128_rr_arbiter #(.N(NUM_REQ)) u_arb (
        .i_req     (req_valid_i & ~{NUM_REQ{rst_i}}),
        .i_ptr     (r_ptr),
        .o_gnt     (w_gnt),
        .o_nxt_ptr (w_nxt_ptr)
    );

    assign req_ready_o = w_gnt;
    assign w_any       = |w_gnt;
    assign w_set       = alloc_valid_i ? (CAP_REG_COUNT'(1) << alloc_addr_i) : '0;
    assign w_clr       = cf_we_o ? (CAP_REG_COUNT'(1) << cf_waddr_o) : '0;

    // route the granted requester's address and data into the write stage
    always_comb begin
        w_sel = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_gnt[k]) begin
                w_sel.addr = req_addr_i[k*CAP_REG_AW +: CAP_REG_AW];
                w_sel.data = req_data_i[k*C_XLEN +: C_XLEN];
            end
        end
    end

    // write stage and RR pointer; address/data hold when nothing is granted
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cf_we_o    <= 1'b0;
            cf_waddr_o <= '0;
            cf_wdata_o <= '0;
            r_ptr      <= '0;
        end else begin
            cf_we_o <= w_any;
            r_ptr   <= w_nxt_ptr;
            if (w_any) begin
                cf_waddr_o <= w_sel.addr;
                cf_wdata_o <= w_sel.data;
            end
        end
    end

    // scoreboard: a new allocation beats both flush and the committing write
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_o   <= '0;
            sb_err_o <= 1'b0;
        end else begin
            busy_o <= w_set | (flush_i ? '0 : (busy_o & ~w_clr));
            if (cf_we_o && !busy_o[cf_waddr_o] && !flush_i) sb_err_o <= 1'b1;
        end
    end
endmodule

// File: tb/tb_amber128_capfile_wb_arb.sv
// tb_amber128_capfile_wb_arb: directed and random checks against a cycle-level reference model
module tb_amber128_capfile_wb_arb;
    import amber128_pkg::*;
    localparam int NR = 3;
    localparam int AW = CAP_REG_AW;
    localparam int XW = C_XLEN;
    localparam int RC = CAP_REG_COUNT;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    logic [NR-1:0]    req_valid_i = '0;
    logic [NR-1:0]    req_ready_o;
    logic [NR*AW-1:0] req_addr_i = '0;
    logic [NR*XW-1:0] req_data_i = '0;
    logic             alloc_valid_i = 1'b0;
    logic [AW-1:0]    alloc_addr_i = '0;
    logic             flush_i = 1'b0;
    logic [RC-1:0]    busy_o;
    logic             cf_we_o;
    logic [AW-1:0]    cf_waddr_o;
    logic [XW-1:0]    cf_wdata_o;
    logic             sb_err_o;

    amber128_capfile_wb_arb #(.NUM_REQ(NR)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_addr_i(req_addr_i), .req_data_i(req_data_i), .alloc_valid_i(alloc_valid_i),
        .alloc_addr_i(alloc_addr_i), .flush_i(flush_i), .busy_o(busy_o), .cf_we_o(cf_we_o),
        .cf_waddr_o(cf_waddr_o), .cf_wdata_o(cf_wdata_o), .sb_err_o(sb_err_o)
    );

    always #5 clk_i = ~clk_i;

    logic [NR-1:0] s_v;
    logic [AW-1:0] s_a [NR];
    logic [XW-1:0] s_d [NR];
    logic          s_al, s_fl;
    logic [AW-1:0] s_aa;

    int            m_ptr;
    logic          m_we;
    logic [AW-1:0] m_waddr;
    logic [XW-1:0] m_wdata;
    logic [RC-1:0] m_busy;
    logic          m_err;
    logic [NR-1:0] m_gnt, last_gnt;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [XW-1:0] got, input logic [XW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        s_v  = '0;
        s_al = 1'b0;
        s_fl = 1'b0;
        s_aa = '0;
        for (int k = 0; k < NR; k++) begin
            s_a[k] = '0;
            s_d[k] = '0;
        end
    endtask

    task automatic drive();
        req_valid_i   = s_v;
        alloc_valid_i = s_al;
        alloc_addr_i  = s_aa;
        flush_i       = s_fl;
        for (int k = 0; k < NR; k++) begin
            req_addr_i[k*AW +: AW] = s_a[k];
            req_data_i[k*XW +: XW] = s_d[k];
        end
    endtask

    task automatic model_reset();
        m_ptr    = 0;
        m_we     = 1'b0;
        m_waddr  = '0;
        m_wdata  = '0;
        m_busy   = '0;
        m_err    = 1'b0;
        last_gnt = '0;
    endtask

    task automatic settle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset(input logic [NR-1:0] v);
        @(negedge clk_i);
        rst_i = 1'b1;
        idle();
        s_v = v;
        drive();
        #1;
        check("rst_ready", XW'(req_ready_o), '0);
        check("rst_we", XW'(cf_we_o), '0);
        check("rst_busy", XW'(busy_o), '0);
        check("rst_err", XW'(sb_err_o), '0);
        @(negedge clk_i);
        #1;
        check("rst_ready_hold", XW'(req_ready_o), '0);
        check("rst_waddr", XW'(cf_waddr_o), '0);
        check("rst_wdata", cf_wdata_o, '0);
        idle();
        drive();
        model_reset();
        rst_i = 1'b0;
    endtask

    // one cycle: drive, compare against the model, then advance the model across the coming edge
    task automatic step();
        int g;
        logic [RC-1:0] nb;
        @(negedge clk_i);
        drive();
        #1;
        g = -1;
        for (int i = 0; i < NR; i++)
            if (g < 0 && s_v[(m_ptr + i) % NR]) g = (m_ptr + i) % NR;
        m_gnt = '0;
        if (g >= 0) m_gnt[g] = 1'b1;
        check("ready", XW'(req_ready_o), XW'(m_gnt));
        check("we", XW'(cf_we_o), XW'(m_we));
        check("waddr", XW'(cf_waddr_o), XW'(m_waddr));
        check("wdata", cf_wdata_o, m_wdata);
        check("busy", XW'(busy_o), XW'(m_busy));
        check("err", XW'(sb_err_o), XW'(m_err));
        nb = s_fl ? '0 : m_busy;
        if (!s_fl && m_we) nb[m_waddr] = 1'b0;
        if (s_al) nb[s_aa] = 1'b1;
        if (m_we && !m_busy[m_waddr] && !s_fl) m_err = 1'b1;
        m_busy = nb;
        if (g >= 0) begin
            m_we    = 1'b1;
            m_waddr = s_a[g];
            m_wdata = s_d[g];
            m_ptr   = (g + 1) % NR;
        end else begin
            m_we = 1'b0;
        end
        last_gnt = m_gnt;
    endtask

    logic [NR-1:0] seq [4];

    initial begin
        seq = '{3'b001, 3'b010, 3'b100, 3'b001};
        idle();
        model_reset();
        // reset with every requester valid, then round-robin from requester 0
        do_reset(3'b111);
        for (int i = 0; i < 4; i++) begin
            idle();
            s_v = 3'b111;
            for (int k = 0; k < NR; k++) begin
                s_a[k] = AW'(k + i);
                s_d[k] = XW'($urandom);
            end
            step();
            check("rr_seq", XW'(req_ready_o), XW'(seq[i]));
        end
        // reset lands while a write sits in the stage
        do_reset(3'b111);
        // single request from requester 1 to r5
        idle(); s_al = 1'b1; s_aa = 4'd5; step();
        idle(); s_v = 3'b010; s_a[1] = 4'd5; s_d[1] = {16{8'hA5}}; step();
        settle();
        check("t2_we", XW'(cf_we_o), XW'(1'b1));
        check("t2_waddr", XW'(cf_waddr_o), XW'(4'd5));
        check("t2_wdata", cf_wdata_o, {16{8'hA5}});
        idle(); step();
        settle();
        check("t2_idle_we", XW'(cf_we_o), '0);
        check("t2_busy5", XW'(busy_o[5]), '0);
        // alloc r7 then commit it
        idle(); s_al = 1'b1; s_aa = 4'd7; step();
        settle();
        check("t3_busy7_set", XW'(busy_o[7]), XW'(1'b1));
        idle(); s_v = 3'b001; s_a[0] = 4'd7; s_d[0] = XW'(64'h1234_5678_9abc_def0); step();
        idle(); step();
        settle();
        check("t3_busy7_clr", XW'(busy_o[7]), '0);
        check("t3_err", XW'(sb_err_o), '0);
        // alloc r3 in the same cycle r3 commits
        idle(); s_al = 1'b1; s_aa = 4'd3; step();
        idle(); s_v = 3'b100; s_a[2] = 4'd3; s_d[2] = XW'(32'hcafe); step();
        idle(); s_al = 1'b1; s_aa = 4'd3; step();
        check("t4_commit_r3", XW'({cf_we_o, cf_waddr_o}), XW'({1'b1, 4'd3}));
        settle();
        check("t4_busy3", XW'(busy_o[3]), XW'(1'b1));
        // flush with a simultaneous alloc while a write is in the stage
        idle(); s_al = 1'b1; s_aa = 4'd2; step();
        idle(); s_al = 1'b1; s_aa = 4'd9; step();
        idle(); s_v = 3'b001; s_a[0] = 4'd9; s_d[0] = XW'(32'hbeef); step();
        idle(); s_fl = 1'b1; s_al = 1'b1; s_aa = 4'd4; step();
        check("t5_stage_we", XW'(cf_we_o), XW'(1'b1));
        settle();
        check("t5_busy", XW'(busy_o), XW'(16'h0010));
        check("t5_err", XW'(sb_err_o), '0);
        // write to a register that is not busy
        idle(); s_v = 3'b010; s_a[1] = 4'd11; s_d[1] = XW'(32'hdead); step();
        idle(); step();
        settle();
        check("t6_err_set", XW'(sb_err_o), XW'(1'b1));
        for (int i = 0; i < 5; i++) begin
            idle(); step();
        end
        check("t6_err_sticky", XW'(sb_err_o), XW'(1'b1));
        // randomized traffic; requesters hold their request until granted
        do_reset('0);
        idle();
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                do_reset(NR'($urandom));
                idle();
            end
            for (int k = 0; k < NR; k++) begin
                if (!s_v[k] || last_gnt[k]) begin
                    s_v[k] = ($urandom_range(0, 2) != 0);
                    s_a[k] = AW'($urandom_range(0, RC - 1));
                    s_d[k] = {$urandom, $urandom, $urandom, $urandom};
                end
            end
            s_al = ($urandom_range(0, 2) == 0);
            s_aa = AW'($urandom_range(0, RC - 1));
            s_fl = ($urandom_range(0, 19) == 0);
            step();
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
